// File: rtl/noc_switch_allocator.sv
// 5-port wormhole switch allocator: per-output IDLE/LOCKED FSM with a round-robin
// pointer, packet lock held from head allocation until the tail flit is acked.
module noc_switch_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_dest_i,
  input  logic [4:0]  req_tail_i,
  input  logic [4:0]  out_ready_i,
  output logic [24:0] grant_o,
  output logic [4:0]  in_ack_o,
  output logic [4:0]  out_busy_o,
  output logic        err_o
);

  // state   | meaning
  // IDLE    | output free, arbitrates among requesting inputs
  // LOCKED  | output owned by r_owner until its tail flit is acked
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t     r_state [5];
  state_t     w_state_nxt [5];
  logic [2:0] r_owner [5];
  logic [2:0] w_owner_nxt [5];
  logic [2:0] r_ptr [5];
  logic [2:0] w_ptr_nxt [5];
  logic       r_err;
  logic       w_err_nxt;

  logic [2:0] w_dest [5];
  logic [4:0] w_req [5];
  logic [4:0] w_in_locked;
  logic [4:0] w_illegal;
  logic [4:0] w_ack;

  function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] s;
    logic [2:0] pick;
    pick = ptr;
    // Walk the scan order backwards so the candidate closest to ptr wins.
    for (int k = 4; k >= 0; k--) begin
      s = {1'b0, ptr} + 4'(k);
      if (s >= 4'd5) s = s - 4'd5;
      if (req[s[2:0]]) pick = s[2:0];
    end
    return pick;
  endfunction

  always_comb begin
    w_in_locked = '0;
    for (int o = 0; o < 5; o++) begin
      if (r_state[o] == ST_LOCKED) w_in_locked[r_owner[o]] = 1'b1;
    end
  end

  always_comb begin
    w_illegal = '0;
    for (int o = 0; o < 5; o++) w_req[o] = '0;
    for (int i = 0; i < 5; i++) begin
      w_dest[i] = req_dest_i[3*i +: 3];
      if (req_valid_i[i] && !w_in_locked[i]) begin
        if (w_dest[i] > 3'd4 || w_dest[i] == 3'(i)) w_illegal[i] = 1'b1;
        else w_req[w_dest[i]][i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_ack = '0;
    for (int o = 0; o < 5; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      case (r_state[o])
        ST_IDLE: begin
          if (|w_req[o]) begin
            w_state_nxt[o] = ST_LOCKED;
            w_owner_nxt[o] = rr_pick(w_req[o], r_ptr[o]);
          end
        end
        ST_LOCKED: begin
          if (req_valid_i[r_owner[o]] && out_ready_i[o]) begin
            w_ack[r_owner[o]] = 1'b1;
            if (req_tail_i[r_owner[o]]) begin
              w_state_nxt[o] = ST_IDLE;
              w_ptr_nxt[o]   = (r_owner[o] == 3'd4) ? 3'd0 : r_owner[o] + 3'd1;
            end
          end
        end
        default: w_state_nxt[o] = ST_IDLE;
      endcase
    end
    w_err_nxt = r_err | (|w_illegal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
      r_err <= w_err_nxt;
    end
  end

  // Outputs are masked while rst is high so nothing leaks during the reset cycle.
  always_comb begin
    grant_o    = '0;
    out_busy_o = '0;
    for (int o = 0; o < 5; o++) begin
      if (r_state[o] == ST_LOCKED && !rst) begin
        grant_o[5*o +: 5] = 5'b00001 << r_owner[o];
        out_busy_o[o]     = 1'b1;
      end
    end
    in_ack_o = rst ? 5'b0 : w_ack;
    err_o    = r_err & ~rst;
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed vector table for the switch allocator plus a round-robin fairness sequence.
module tb_noc_switch_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req_valid_i = '0;
  logic [14:0] req_dest_i = '0;
  logic [4:0]  req_tail_i = '0;
  logic [4:0]  out_ready_i = '0;
  logic [24:0] grant_o;
  logic [4:0]  in_ack_o;
  logic [4:0]  out_busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  noc_switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_dest_i(req_dest_i),
    .req_tail_i(req_tail_i), .out_ready_i(out_ready_i),
    .grant_o(grant_o), .in_ack_o(in_ack_o),
    .out_busy_o(out_busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  valid;
    logic [14:0] dest;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [24:0] grant;
    logic [4:0]  ack;
    logic [4:0]  busy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] dp(input int i, input int d);
    logic [14:0] v;
    v = 15'(d) << (3 * i);
    return v;
  endfunction

  function automatic logic [24:0] gp(input int o, input int i);
    logic [24:0] v;
    v = 25'd1 << (5 * o + i);
    return v;
  endfunction

  task automatic add(input logic r, input logic [4:0] v, input logic [14:0] d,
                     input logic [4:0] t, input logic [4:0] rd, input logic [24:0] g,
                     input logic [4:0] a, input logic [4:0] b, input logic e);
    vec_t x;
    x.rst = r; x.valid = v; x.dest = d; x.tail = t; x.ready = rd;
    x.grant = g; x.ack = a; x.busy = b; x.err = e;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int n, input logic [24:0] act, input logic [24:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  initial begin
    logic [14:0] d_par, d_f, d_fair;
    logic [4:0] exp_g;
    int waited;
    int order[8];

    // single flit 4 -> 0
    add(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b10000, dp(4,0), 5'b10000, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b10000, dp(4,0), 5'b10000, 5'b11111, gp(0,4), 5'b10000, 5'b00001, 0);
    add(0, 5'b00000, 0, 0, 5'b11111, 0, 0, 0, 0);
    // contention 1,2,3 -> 4
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, gp(4,1), 5'b00010, 5'b10000, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, gp(4,2), 5'b00100, 5'b10000, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, gp(4,3), 5'b01000, 5'b10000, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b01110, dp(1,4)|dp(2,4)|dp(3,4), 5'b11111, 5'b11111, gp(4,1), 5'b00010, 5'b10000, 0);
    // multi-flit lock 0 -> 2 with 1 contending and two stalled cycles
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00000, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00000, 5'b11111, gp(2,0), 5'b00001, 5'b00100, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00000, 5'b11011, gp(2,0), 5'b00000, 5'b00100, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00000, 5'b11011, gp(2,0), 5'b00000, 5'b00100, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00000, 5'b11111, gp(2,0), 5'b00001, 5'b00100, 0);
    add(0, 5'b00011, dp(0,2)|dp(1,2), 5'b00001, 5'b11111, gp(2,0), 5'b00001, 5'b00100, 0);
    add(0, 5'b00010, dp(1,2), 5'b00000, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b00010, dp(1,2), 5'b00000, 5'b11111, gp(2,1), 5'b00010, 5'b00100, 0);
    // illegal: U-turn, then out-of-range destination
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b01000, dp(3,3), 5'b01000, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b00000, 0, 0, 5'b11111, 0, 0, 0, 1);
    add(0, 5'b00000, 0, 0, 5'b11111, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b00001, dp(0,6), 5'b00001, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b00000, 0, 0, 5'b11111, 0, 0, 0, 1);
    // parallel 0->1, 1->0, 2->3, 3->2
    d_par = dp(0,1)|dp(1,0)|dp(2,3)|dp(3,2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b01111, d_par, 5'b01111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b01111, d_par, 5'b01111, 5'b11111, gp(1,0)|gp(0,1)|gp(3,2)|gp(2,3), 5'b01111, 5'b01111, 0);
    add(0, 5'b00000, 0, 0, 5'b11111, 0, 0, 0, 0);
    // reset mid-packet, then fresh allocation with pointers at 0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5'b00100, dp(2,0), 5'b00000, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b00100, dp(2,0), 5'b00000, 5'b11111, gp(0,2), 5'b00100, 5'b00001, 0);
    add(1, 5'b00100, dp(2,0), 5'b00000, 5'b11111, 0, 0, 0, 0);
    d_f = dp(1,0)|dp(2,0)|dp(0,2)|dp(4,2);
    add(0, 5'b10111, d_f, 5'b11111, 5'b11111, 0, 0, 0, 0);
    add(0, 5'b10111, d_f, 5'b11111, 5'b11111, gp(0,1)|gp(2,0), 5'b00011, 5'b00101, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      rst = vecs[n].rst;
      req_valid_i = vecs[n].valid;
      req_dest_i = vecs[n].dest;
      req_tail_i = vecs[n].tail;
      out_ready_i = vecs[n].ready;
      #1;
      chk("grant", n, grant_o, vecs[n].grant);
      chk("ack", n, 25'(in_ack_o), 25'(vecs[n].ack));
      chk("busy", n, 25'(out_busy_o), 25'(vecs[n].busy));
      chk("err", n, 25'(err_o), 25'(vecs[n].err));
    end

    // fairness: inputs 0,1,3,4 continuously request output 2 with single flits
    order = '{0, 1, 3, 4, 0, 1, 3, 4};
    d_fair = dp(0,2)|dp(1,2)|dp(3,2)|dp(4,2);
    @(negedge clk);
    rst = 1'b1;
    req_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid_i = 5'b11011;
    req_dest_i = d_fair;
    req_tail_i = 5'b11111;
    out_ready_i = 5'b11111;
    #1;
    for (int k = 0; k < 8; k++) begin
      waited = 0;
      while (!out_busy_o[2] && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("fair_timeout", k, 25'(waited < 10), 25'd1);
      exp_g = 5'b00001 << order[k];
      chk("fair_winner", k, 25'(grant_o[14:10]), 25'(exp_g));
      chk("fair_ack", k, 25'(in_ack_o), 25'(exp_g));
      @(negedge clk);
      #1;
    end
    chk("fair_err", 0, 25'(err_o), 25'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
